// File: rtl/pc_sequencer.sv
// picoMips program-flow controller: owns the PC and sequences branch,
// jump, call/return, multiply stall and blocking input-port waits.
module pc_sequencer #(
    parameter int PC_WIDTH    = 7,
    parameter int STACK_DEPTH = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                               Clock,
    input  logic                               nReset,
    input  logic                               Branch,
    input  logic                               BranchTaken,
    input  logic [PC_WIDTH-1:0]                BranchOffset,
    input  logic                               Jump,
    input  logic                               Call,
    input  logic                               Return,
    input  logic [PC_WIDTH-1:0]                JumpTarget,
    input  logic                               MulStart,
    input  logic                               WaitIn,
    input  logic                               InValid,
    output logic                               InAck,
    output logic [PC_WIDTH-1:0]                ProgramCounter,
    output logic                               PCHold,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   StackDepth,
    output logic                               Fault
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        WAIT_IN,
        FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, stack_top;
    logic [DW-1:0]       depth_q, depth_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                push;
    logic                in_ack;

    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign stack_top = stack_q[AW'(depth_q - DW'(1))];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        in_ack  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (Return) begin
                    if (depth_q == '0) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = stack_top;
                        depth_d = depth_q - DW'(1);
                    end
                end else if (Call) begin
                    if (depth_q == DW'(STACK_DEPTH)) begin
                        state_d = FAULT;
                    end else begin
                        push    = 1'b1;
                        pc_d    = JumpTarget;
                        depth_d = depth_q + DW'(1);
                    end
                end else if (Jump) begin
                    pc_d = JumpTarget;
                end else if (Branch && BranchTaken) begin
                    pc_d = pc_q + BranchOffset;
                end else if (MulStart && (MUL_LATENCY > 0)) begin
                    cnt_d   = CW'(MUL_LATENCY - 1);
                    state_d = STALL;
                end else if (WaitIn && InValid) begin
                    in_ack = 1'b1;
                    pc_d   = pc_inc;
                end else if (WaitIn) begin
                    state_d = WAIT_IN;
                end else begin
                    pc_d = pc_inc;
                end
            end
            STALL: begin
                if (cnt_q == '0) begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_IN: begin
                if (InValid) begin
                    in_ack  = 1'b1;
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end
            FAULT: begin
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= RUN;
            pc_q    <= '0;
            depth_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
        end
    end

    // Return-stack contents are don't-care after reset.
    always_ff @(posedge Clock) begin
        if (push) begin
            stack_q[AW'(depth_q)] <= pc_inc;
        end
    end

    assign InAck          = in_ack;
    assign ProgramCounter = pc_q;
    assign StackDepth     = depth_q;
    assign PCHold         = (state_q != RUN);
    assign Fault          = (state_q == FAULT);

endmodule
